// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall merge, exception/ERET flush sequencing, stall watchdog
//               and stall performance counter for the 5-stage core.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE    = 32'h0000_000e,
    parameter int          DRAIN_CYCLES = 3,
    parameter int          TIMEOUT      = 1024,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DRN_W-1:0] c_drain_load = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [WD_W-1:0]  c_wd_max     = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DRN_W-1:0]   r_drain;
    logic [DRN_W-1:0]   w_drain_nxt;
    logic [WD_W-1:0]    r_wd;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cycles;
    logic [5:0]         w_prio_stall;
    logic               w_stalled;

    // First matching request wins; WB is never held.
    always_comb begin
        w_prio_stall = 6'b000000;
        if (stallreq_mem)
            w_prio_stall = 6'b011111;
        else if (stallreq_ex)
            w_prio_stall = 6'b001111;
        else if (stallreq_id)
            w_prio_stall = 6'b000111;
        else if (stallreq_if)
            w_prio_stall = 6'b000011;
    end

    always_comb begin
        stall       = 6'b000000;
        flush       = 1'b0;
        new_pc      = 32'h0000_0000;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (excepttype_i != 32'h0000_0000) begin
                        flush       = 1'b1;
                        new_pc      = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                        w_state_nxt = FLUSH;
                    end else begin
                        stall = w_prio_stall;
                    end
                end
                FLUSH: begin
                    w_drain_nxt = c_drain_load;
                    w_state_nxt = DRAIN;
                end
                DRAIN: begin
                    // Refill only progresses on cycles where the PC advances.
                    stall = w_prio_stall;
                    if (!w_prio_stall[0]) begin
                        if (r_drain == '0)
                            w_state_nxt = RUN;
                        else
                            w_drain_nxt = r_drain - DRN_W'(1);
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign w_stalled = (stall != 6'b000000) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_drain   <= '0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            if (w_stalled) begin
                if (r_wd == c_wd_max)
                    r_timeout <= 1'b1;
                else
                    r_wd <= r_wd + WD_W'(1);
            end else begin
                r_wd <= '0;
            end
            if ((stall != 6'b000000) && (r_cycles != c_cnt_max))
                r_cycles <= r_cycles + CNT_W'(1);
        end
    end

    assign stall_timeout = r_timeout;
    assign stall_cycles  = r_cycles;

endmodule
`default_nettype wire
